clk_div_gen: RTL and testbench

CLK_DIV_GEN -- requirements
Module: clk_div_gen

---
 rtl/clk_div_pkg.sv | 14 +
 rtl/clk_div_ch.sv | 83 ++++++++
 rtl/clk_div_gen.sv | 50 +++++
 tb/tb_clk_div_gen.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared constants and per-channel status record for the clk_div_gen divider bank.
package clk_div_pkg;

    localparam int CLK_DIV_CNT_W   = 26;
    localparam int CLK_DIV_DEF_DIV = 40;
    localparam int CH_IDX_W        = 4;

    typedef struct packed {
        logic clk_div;
        logic tick;
        logic pend_vld;
    } ch_state_t;

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: half-period counter, 50% duty output, tick and period-aligned divisor switch.
// Optional CLK_DIV_SYNC_EN adds a sync input that restarts the phase and applies pending divisors.
module clk_div_ch
    import clk_div_pkg::*;
#(
    parameter int CNT_W   = CLK_DIV_CNT_W,
    parameter int DEF_DIV = CLK_DIV_DEF_DIV
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             wr_en,
    input  logic [CNT_W-1:0] wr_div,
`ifdef CLK_DIV_SYNC_EN
    input  logic             sync,
`endif
    output logic             clk_div,
    output logic             tick,
    output logic             cfg_pending
);

    logic [CNT_W-1:0] div_q;
    logic [CNT_W-1:0] pend_q;
    logic [CNT_W-1:0] cnt;
    ch_state_t        st;

    logic running;
    logic at_term;
    logic rise;
    logic fall;
    logic apply;

    // A disabled channel keeps running until its high phase has completed.
    assign running = (div_q != '0) && (en || st.clk_div);
    assign at_term = (cnt == div_q - CNT_W'(1));
    assign rise    = running && at_term && !st.clk_div;
    assign fall    = running && at_term && st.clk_div;
    assign apply   = st.pend_vld && (fall || !running);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q  <= CNT_W'(DEF_DIV);
            pend_q <= '0;
            cnt    <= '0;
            st     <= '0;
        end else begin
            st.tick <= rise;
            if (!running || apply) begin
                cnt        <= '0;
                st.clk_div <= 1'b0;
            end else if (at_term) begin
                cnt        <= '0;
                st.clk_div <= ~st.clk_div;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end

            if (apply) div_q <= pend_q;

            // A write landing on the switch edge stays pending for the next period.
            if (wr_en) begin
                pend_q      <= wr_div;
                st.pend_vld <= 1'b1;
            end else if (apply) begin
                st.pend_vld <= 1'b0;
            end
`ifdef CLK_DIV_SYNC_EN
            if (sync) begin
                cnt        <= '0;
                st.clk_div <= 1'b0;
                st.tick    <= 1'b0;
                if (st.pend_vld) div_q <= pend_q;
                if (!wr_en) st.pend_vld <= 1'b0;
            end
`endif
        end
    end

    assign clk_div     = st.clk_div;
    assign tick        = st.tick;
    assign cfg_pending = st.pend_vld;

endmodule

// File: rtl/clk_div_gen.sv
// Bank of NUM_CH independent clock dividers; this level only decodes divisor writes.
// Define CLK_DIV_SYNC_EN to make the global sync phase-restart input functional.
module clk_div_gen
    import clk_div_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = CLK_DIV_CNT_W,
    parameter int DEF_DIV = CLK_DIV_DEF_DIV
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_CH-1:0]   en,
    input  logic                cfg_we,
    input  logic [CH_IDX_W-1:0] cfg_ch,
    input  logic [CNT_W-1:0]    cfg_div,
    input  logic                sync,
    output logic [NUM_CH-1:0]   clk_div,
    output logic [NUM_CH-1:0]   tick,
    output logic [NUM_CH-1:0]   cfg_pending
);

`ifndef CLK_DIV_SYNC_EN
    logic unused_sync;
    assign unused_sync = sync;
`endif

    // Channel indices at or above NUM_CH match no instance, so such writes are dropped.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic wr_en;
        assign wr_en = cfg_we && (cfg_ch == CH_IDX_W'(i));

        clk_div_ch #(
            .CNT_W   (CNT_W),
            .DEF_DIV (DEF_DIV)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .en          (en[i]),
            .wr_en       (wr_en),
            .wr_div      (cfg_div),
`ifdef CLK_DIV_SYNC_EN
            .sync        (sync),
`endif
            .clk_div     (clk_div[i]),
            .tick        (tick[i]),
            .cfg_pending (cfg_pending[i])
        );
    end

endmodule

// File: tb/tb_clk_div_gen.sv
// Directed bench for clk_div_gen: a per-cycle vector table plus hand-written multi-cycle sequences.
module tb_clk_div_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  en;
    logic        cfg_we;
    logic [3:0]  cfg_ch;
    logic [25:0] cfg_div;
    logic        sync;
    logic [3:0]  clk_div;
    logic [3:0]  tick;
    logic [3:0]  cfg_pending;

    int checks = 0;
    int errors = 0;

    clk_div_gen #(.NUM_CH(4), .CNT_W(26), .DEF_DIV(40)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .cfg_we      (cfg_we),
        .cfg_ch      (cfg_ch),
        .cfg_div     (cfg_div),
        .sync        (sync),
        .clk_div     (clk_div),
        .tick        (tick),
        .cfg_pending (cfg_pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  en;
        logic        we;
        logic [25:0] div;
        logic [2:0]  exp;   // {clk_div[1], tick[1], cfg_pending[1]}
    } vec_t;

    vec_t tbl[21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int ch, input int d);
        cfg_we  = 1'b1;
        cfg_ch  = 4'(ch);
        cfg_div = 26'(d);
        step();
        cfg_we  = 1'b0;
    endtask

    task automatic run_until(input int ch, input logic val, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (clk_div[ch] !== val && n < 200);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int bad;
        tbl[0]  = '{4'b0000, 1'b1, 26'd5, 3'b001};
        tbl[1]  = '{4'b0000, 1'b0, 26'd0, 3'b000};
        tbl[2]  = '{4'b0010, 1'b0, 26'd0, 3'b000};
        tbl[3]  = '{4'b0010, 1'b0, 26'd0, 3'b000};
        tbl[4]  = '{4'b0010, 1'b0, 26'd0, 3'b000};
        tbl[5]  = '{4'b0010, 1'b0, 26'd0, 3'b000};
        tbl[6]  = '{4'b0010, 1'b0, 26'd0, 3'b110};
        tbl[7]  = '{4'b0010, 1'b1, 26'd3, 3'b101};
        tbl[8]  = '{4'b0010, 1'b0, 26'd0, 3'b101};
        tbl[9]  = '{4'b0010, 1'b0, 26'd0, 3'b101};
        tbl[10] = '{4'b0010, 1'b0, 26'd0, 3'b101};
        tbl[11] = '{4'b0010, 1'b0, 26'd0, 3'b000};
        tbl[12] = '{4'b0010, 1'b0, 26'd0, 3'b000};
        tbl[13] = '{4'b0010, 1'b0, 26'd0, 3'b000};
        tbl[14] = '{4'b0010, 1'b0, 26'd0, 3'b110};
        tbl[15] = '{4'b0010, 1'b0, 26'd0, 3'b100};
        tbl[16] = '{4'b0010, 1'b0, 26'd0, 3'b100};
        tbl[17] = '{4'b0010, 1'b0, 26'd0, 3'b000};
        tbl[18] = '{4'b0010, 1'b0, 26'd0, 3'b000};
        tbl[19] = '{4'b0010, 1'b0, 26'd0, 3'b000};
        tbl[20] = '{4'b0010, 1'b0, 26'd0, 3'b110};

        rst = 1'b1; en = 4'b0000; cfg_we = 1'b0; cfg_ch = 4'd0; cfg_div = 26'd0; sync = 1'b0;
        #12;
        chk("reset_clk_div", 32'(clk_div), 0);
        chk("reset_tick", 32'(tick), 0);
        chk("reset_pending", 32'(cfg_pending), 0);
        step();
        rst = 1'b0;

        // Default divisor 40 on channel 0, then en drop during high phase.
        en = 4'b0001;
        run_until(0, 1'b1, n);
        chk("default_first_rise", n, 40);
        chk("default_tick_at_rise", 32'(tick[0]), 1);
        run_until(0, 1'b0, n);
        chk("default_high_len", n, 40);
        chk("default_tick_low", 32'(tick[0]), 0);
        run_until(0, 1'b1, n);
        chk("default_low_len", n, 40);
        chk("default_tick_period", 32'(tick[0]), 1);
        en = 4'b0000;
        run_until(0, 1'b0, n);
        chk("ch0_en_drop_high_len", n, 40);

        // Channel 1 per-cycle table: N=5, then N=3 written mid-high phase.
        for (int i = 0; i < 21; i++) begin
            en      = tbl[i].en;
            cfg_we  = tbl[i].we;
            cfg_ch  = 4'd1;
            cfg_div = tbl[i].div;
            step();
            chk($sformatf("table_row%0d", i), 32'({clk_div[1], tick[1], cfg_pending[1]}), 32'(tbl[i].exp));
        end
        cfg_we = 1'b0;

        // Write landing on the 1->0 edge stays pending for one more period.
        step();
        step();
        wr(1, 2);
        chk("fall_write_clk", 32'(clk_div[1]), 0);
        chk("fall_write_pending", 32'(cfg_pending[1]), 1);
        run_until(1, 1'b1, n);
        chk("fall_write_old_low", n, 3);
        chk("fall_write_still_pending", 32'(cfg_pending[1]), 1);
        run_until(1, 1'b0, n);
        chk("fall_write_old_high", n, 3);
        chk("fall_write_applied", 32'(cfg_pending[1]), 0);
        run_until(1, 1'b1, n);
        chk("fall_write_new_low", n, 2);

        // Channel 2: last write wins, then N=0 stops the channel.
        wr(2, 4);
        step();
        chk("ch2_idle_apply", 32'(cfg_pending[2]), 0);
        en = en | 4'b0100;
        run_until(2, 1'b1, n);
        chk("ch2_first_rise", n, 4);
        wr(2, 7);
        wr(2, 2);
        chk("ch2_pending", 32'(cfg_pending[2]), 1);
        run_until(2, 1'b0, n);
        chk("ch2_old_high", n, 2);
        run_until(2, 1'b1, n);
        chk("ch2_last_write_wins", n, 2);
        chk("ch2_pending_cleared", 32'(cfg_pending[2]), 0);
        wr(2, 0);
        run_until(2, 1'b0, n);
        chk("ch2_zero_at_fall", n, 1);
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (clk_div[2] !== 1'b0 || tick[2] !== 1'b0) bad++;
        end
        chk("ch2_zero_silent", bad, 0);

        // Channel 3: en dropped two cycles into high phase.
        wr(3, 6);
        step();
        en = en | 4'b1000;
        run_until(3, 1'b1, n);
        chk("ch3_first_rise", n, 6);
        step();
        step();
        en = en & 4'b0111;
        run_until(3, 1'b0, n);
        chk("ch3_en_drop_rest_high", n, 4);
        bad = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (clk_div[3] !== 1'b0 || tick[3] !== 1'b0) bad++;
        end
        chk("ch3_held_low", bad, 0);

        // Out-of-range channel index must not touch any channel.
        wr(15, 1);
        chk("bad_ch_pending", 32'(cfg_pending), 0);
        run_until(1, 1'b1, n);
        run_until(1, 1'b0, n);
        chk("bad_ch_ch1_unchanged", n, 2);
        en = en | 4'b1000;
        run_until(3, 1'b1, n);
        chk("bad_ch_ch3_unchanged", n, 6);

        // Reset mid-period with a pending write.
        wr(1, 5);
        chk("pre_reset_pending", 32'(cfg_pending[1]), 1);
        #3;
        rst = 1'b1;
        #1;
        chk("async_reset_clk_div", 32'(clk_div), 0);
        chk("async_reset_tick", 32'(tick), 0);
        chk("async_reset_pending", 32'(cfg_pending), 0);
        step();
        rst = 1'b0;
        en  = 4'b0010;
        run_until(1, 1'b1, n);
        chk("post_reset_def_rise", n, 40);
        run_until(1, 1'b0, n);
        chk("post_reset_def_high", n, 40);

`ifdef CLK_DIV_SYNC_EN
        begin
            int r0;
            int r1;
            en = 4'b0000;
            wr(0, 3);
            wr(1, 5);
            step();
            en = 4'b0011;
            for (int k = 0; k < 7; k++) step();
            sync = 1'b1;
            step();
            sync = 1'b0;
            chk("sync_forces_low", 32'(clk_div & 4'b0011), 0);
            r0 = 0;
            r1 = 0;
            for (int k = 1; k <= 8; k++) begin
                step();
                if (clk_div[0] === 1'b1 && r0 == 0) r0 = k;
                if (clk_div[1] === 1'b1 && r1 == 0) r1 = k;
            end
            chk("sync_ch0_rise", r0, 3);
            chk("sync_ch1_rise", r1, 5);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
